// File: rtl/stream_arb_2x1.sv
// Two-source packet-aware round-robin arbiter feeding one registered output stream.
// The grant is held for a whole packet; sel reports which source the held beat came from.
module stream_arb_2x1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    input  logic              y_ready,
    output logic              sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   load_en;
    logic   grant_vld;
    logic   grant_id;
    logic   accept;
    logic   acc_last;

    assign load_en = !y_valid || y_ready;

    // Grant selection: a lock pins the grant even while the locked source idles.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = SRC_A;
        case (state)
            LOCK_A: begin
                grant_vld = 1'b1;
                grant_id  = SRC_A;
            end
            LOCK_B: begin
                grant_vld = 1'b1;
                grant_id  = SRC_B;
            end
            default: begin
                if (a_valid && b_valid) begin
                    grant_vld = 1'b1;
                    grant_id  = ~last_grant;
                end else if (a_valid) begin
                    grant_vld = 1'b1;
                    grant_id  = SRC_A;
                end else if (b_valid) begin
                    grant_vld = 1'b1;
                    grant_id  = SRC_B;
                end
            end
        endcase
    end

    // Readies are held low through reset so no beat is consumed then.
    assign a_ready  = rst_n && load_en && grant_vld && (grant_id == SRC_A);
    assign b_ready  = rst_n && load_en && grant_vld && (grant_id == SRC_B);
    assign accept   = (a_ready && a_valid) || (b_ready && b_valid);
    assign acc_last = (grant_id == SRC_B) ? b_last : a_last;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (accept) begin
            if (acc_last) begin
                state_nxt      = IDLE;
                last_grant_nxt = grant_id;
            end else begin
                state_nxt = (grant_id == SRC_B) ? LOCK_B : LOCK_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SRC_B;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Output register stage: loads on accept, empties when drained with nothing to load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
            sel     <= SRC_A;
        end else if (load_en) begin
            if (accept) begin
                y_valid <= 1'b1;
                y_data  <= (grant_id == SRC_B) ? b_data : a_data;
                y_last  <= acc_last;
                sel     <= grant_id;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Directed self-checking bench for stream_arb_2x1: reset, tie alternation, packet lock,
// backpressure, locked-source gap and mid-packet reset.
module tb_stream_arb_2x1;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, a_last, a_ready;
    logic [DATA_W-1:0] a_data;
    logic              b_valid, b_last, b_ready;
    logic [DATA_W-1:0] b_data;
    logic              y_valid, y_last, y_ready, sel;
    logic [DATA_W-1:0] y_data;

    int n_tests = 0;
    int n_fail  = 0;

    stream_arb_2x1 #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
        .sel(sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        y_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
        y_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
            n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b expected 0", sel); end
            n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got a=%b b=%b expected a=0 b=0", a_ready, b_ready); end
        end
        n_tests++; if (y_data !== 8'h00 || y_last !== 1'b0) begin n_fail++; $display("FAIL reset_y_data: got %h/%b expected 00/0", y_data, y_last); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_first_tie: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    endtask

    task automatic test_tie();
        logic [7:0] exp_d;
        do_reset();
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
        y_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = (i % 2 == 1) ? 8'h22 : 8'h11;
            n_tests++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL tie_valid[%0d]: got %b expected 1", i, y_valid); end
            n_tests++; if (y_data !== exp_d) begin n_fail++; $display("FAIL tie_data[%0d]: got %h expected %h", i, y_data, exp_d); end
            n_tests++; if (sel !== 1'(i % 2)) begin n_fail++; $display("FAIL tie_sel[%0d]: got %b expected %0d", i, sel, i % 2); end
        end
    endtask

    task automatic test_lock();
        logic [7:0] beats [3];
        beats[0] = 8'hA0; beats[1] = 8'hA1; beats[2] = 8'hA2;
        do_reset();
        y_ready = 1'b1;
        b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = beats[i];
            a_last = (i == 2);
            #1;
            n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL lock_ready[%0d]: got a=%b b=%b expected a=1 b=0", i, a_ready, b_ready); end
            tick();
            n_tests++; if (y_data !== beats[i] || sel !== 1'b0 || y_last !== (i == 2)) begin n_fail++; $display("FAIL lock_out[%0d]: got %h sel=%b last=%b expected %h sel=0 last=%0d", i, y_data, sel, y_last, beats[i], i == 2); end
        end
        #1;
        n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_fail++; $display("FAIL lock_release_ready: got a=%b b=%b expected a=0 b=1", a_ready, b_ready); end
        tick();
        n_tests++; if (y_data !== 8'hB0 || sel !== 1'b1 || y_valid !== 1'b1) begin n_fail++; $display("FAIL lock_then_b: got %h sel=%b v=%b expected b0 sel=1 v=1", y_data, sel, y_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        y_ready = 1'b0;
        b_valid = 1'b1; b_data = 8'h5A; b_last = 1'b1;
        tick();
        n_tests++; if (y_valid !== 1'b1 || y_data !== 8'h5A || sel !== 1'b1) begin n_fail++; $display("FAIL bp_load: got v=%b %h sel=%b expected v=1 5a sel=1", y_valid, y_data, sel); end
        b_data = 8'h6C;
        a_valid = 1'b1; a_data = 8'h77; a_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got a=%b b=%b expected a=0 b=0", i, a_ready, b_ready); end
            tick();
            n_tests++; if (y_valid !== 1'b1 || y_data !== 8'h5A || y_last !== 1'b1 || sel !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %h last=%b sel=%b expected v=1 5a last=1 sel=1", i, y_valid, y_data, y_last, sel); end
        end
        a_valid = 1'b0;
        y_ready = 1'b1;
        #1;
        n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain_load_ready: got %b expected 1", b_ready); end
        tick();
        n_tests++; if (y_valid !== 1'b1 || y_data !== 8'h6C) begin n_fail++; $display("FAIL bp_no_bubble: got v=%b %h expected v=1 6c", y_valid, y_data); end
        b_valid = 1'b0;
        tick();
        n_tests++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", y_valid); end
    endtask

    task automatic test_gap();
        do_reset();
        y_ready = 1'b1;
        b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b0;
        tick();
        n_tests++; if (y_data !== 8'hB1 || sel !== 1'b1 || y_last !== 1'b0) begin n_fail++; $display("FAIL gap_first: got %h sel=%b last=%b expected b1 sel=1 last=0", y_data, sel, y_last); end
        b_valid = 1'b0;
        a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL gap_a_ready[%0d]: got %b expected 0", i, a_ready); end
            tick();
            n_tests++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL gap_y_valid[%0d]: got %b expected 0", i, y_valid); end
        end
        b_valid = 1'b1; b_data = 8'hB2; b_last = 1'b1;
        tick();
        n_tests++; if (y_valid !== 1'b1 || y_data !== 8'hB2 || sel !== 1'b1 || y_last !== 1'b1) begin n_fail++; $display("FAIL gap_resume: got v=%b %h sel=%b last=%b expected v=1 b2 sel=1 last=1", y_valid, y_data, sel, y_last); end
        #1;
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL gap_release_ready: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
        tick();
        n_tests++; if (y_data !== 8'hAA || sel !== 1'b0) begin n_fail++; $display("FAIL gap_a_next: got %h sel=%b expected aa sel=0", y_data, sel); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        y_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'hC0; a_last = 1'b1;
        tick();
        a_data = 8'hC1; a_last = 1'b0;
        tick();
        n_tests++; if (y_data !== 8'hC1 || y_valid !== 1'b1) begin n_fail++; $display("FAIL mid_locked: got %h v=%b expected c1 v=1", y_data, y_valid); end
        b_valid = 1'b1; b_data = 8'hD0; b_last = 1'b1;
        rst_n = 1'b0;
        tick();
        n_tests++; if (y_valid !== 1'b0 || sel !== 1'b0 || y_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_out: got v=%b sel=%b %h expected v=0 sel=0 00", y_valid, sel, y_data); end
        rst_n = 1'b1;
        a_valid = 1'b0;
        #1;
        n_tests++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got a=%b b=%b expected a=0 b=1", a_ready, b_ready); end
        a_valid = 1'b1; a_data = 8'hC2; a_last = 1'b1;
        #1;
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
        tick();
        n_tests++; if (y_data !== 8'hC2 || sel !== 1'b0 || y_valid !== 1'b1) begin n_fail++; $display("FAIL mid_a_first: got %h sel=%b v=%b expected c2 sel=0 v=1", y_data, sel, y_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        y_ready = 1'b0;
        #2;
        test_reset();
        test_tie();
        test_lock();
        test_backpressure();
        test_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
